sram_axi_arbiter: RTL and testbench

Two-requester SRAM-like to AXI3 master bridge that shares one AXI port between the instruction-fetch interface and the data-memory interface of the CPU core. It sits between the Fetch/Excute stages and the external AXI bus, in place of the core's existing bridge. It sequences one transaction at a time through a read or write state machine. Requests that arrive together are granted round-robin.

---
 rtl/sram_axi_arbiter_if.sv | 96 +++++++++
 rtl/sram_axi_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_axi_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_arbiter_if.sv
// Bus bundle between the core's fetch/data SRAM-like ports and one AXI3 port.
// master: the arbiter side; slave: the core plus the AXI slave, driven by the environment.
interface sram_axi_arbiter_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size, data_wstrb,
    input  data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size, data_wstrb,
    output data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_arbiter.sv
// Round-robin bridge: fetch + data SRAM-like ports onto one AXI3 master,
// one transaction at a time. Ports: clk, rstn (async, low), bus (master).
module sram_axi_arbiter (
  input  logic                 clk,
  input  logic                 rstn,
  sram_axi_arbiter_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AWW, S_B
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_owner;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_aw_done;
  logic        r_w_done;

  logic w_idle;
  logic w_dgnt;
  logic w_ignt;
  logic w_aw_ok;
  logic w_w_ok;
  logic w_unused;

  assign w_unused = ^{bus.inst_wr, bus.rid, bus.rresp,
                      bus.rlast, bus.bid, bus.bresp};

  // r_last: 0 = fetch won last, 1 = data won last.
  // A tie goes to whichever requester did not win last time.
  assign w_idle = (r_state == S_IDLE);
  assign w_dgnt = w_idle & bus.data_req
                & (~bus.inst_req | ~r_last);
  assign w_ignt = w_idle & bus.inst_req
                & (~bus.data_req | r_last);

  assign w_aw_ok = r_aw_done | bus.awready;
  assign w_w_ok  = r_w_done  | bus.wready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b0;
      r_owner   <= 1'b0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_wstrb   <= 4'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_dgnt) begin
            r_owner <= 1'b1;
            r_last  <= 1'b1;
            r_wr    <= bus.data_wr;
            r_size  <= bus.data_size;
            r_wstrb <= bus.data_wstrb;
            r_addr  <= bus.data_addr;
            r_wdata <= bus.data_wdata;
            r_state <= bus.data_wr ? S_AWW : S_AR;
          end else if (w_ignt) begin
            r_owner <= 1'b0;
            r_last  <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= bus.inst_size;
            r_wstrb <= 4'd0;
            r_addr  <= bus.inst_addr;
            r_wdata <= 32'd0;
            r_state <= S_AR;
          end
        end
        S_AR: if (bus.arready) r_state <= S_R;
        S_R:  if (bus.rvalid)  r_state <= S_IDLE;
        S_AWW: begin
          // AW and W may complete in either order or together.
          if (w_aw_ok && w_w_ok) begin
            r_state   <= S_B;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_aw_done <= w_aw_ok;
            r_w_done  <= w_w_ok;
          end
        end
        S_B:  if (bus.bvalid)  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.inst_addr_ok = w_ignt;
  assign bus.data_addr_ok = w_dgnt;
  assign bus.inst_rdata   = bus.rdata;
  assign bus.data_rdata   = bus.rdata;
  assign bus.inst_data_ok = (r_state == S_R) & bus.rvalid
                          & ~r_owner;
  assign bus.data_data_ok = ((r_state == S_R) & bus.rvalid
                             & r_owner)
                          | ((r_state == S_B) & bus.bvalid);

  assign bus.arid    = {3'b000, r_owner};
  assign bus.araddr  = r_addr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, r_size};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'd0;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = (r_state == S_AR);
  assign bus.rready  = (r_state == S_R);

  assign bus.awid    = 4'd1;
  assign bus.awaddr  = r_addr;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, r_size};
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'd0;
  assign bus.awcache = 4'd0;
  assign bus.awprot  = 3'd0;
  assign bus.awvalid = (r_state == S_AWW) & ~r_aw_done;

  assign bus.wid     = 4'd1;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = r_wstrb;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = (r_state == S_AWW) & ~r_w_done & r_wr;
  assign bus.bready  = (r_state == S_B);

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: fetch, tie, store, stall, reset.
// Inputs change on negedge; outputs are checked 1ns later.
module tb_sram_axi_arbiter;
  logic clk;
  logic rstn;
  int   total;
  int   bad;

  sram_axi_arbiter_if bus();

  sram_axi_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.inst_req = 0; bus.inst_wr = 0;
    bus.inst_size = 0; bus.inst_addr = 0;
    bus.data_req = 0; bus.data_wr = 0;
    bus.data_size = 0; bus.data_wstrb = 0;
    bus.data_addr = 0; bus.data_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0;
    bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0;
    bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cyc();
    rstn = 0;
    cyc();
    cyc();
    rstn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    cyc(); #1;
    total++;
    if ({bus.arvalid, bus.rready, bus.awvalid,
         bus.wvalid, bus.bready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_valids got=%b want=00000",
        {bus.arvalid, bus.rready, bus.awvalid,
         bus.wvalid, bus.bready});
    end
    total++;
    if ({bus.inst_addr_ok, bus.data_addr_ok,
         bus.inst_data_ok, bus.data_data_ok} !== 4'b0) begin
      bad++;
      $display("FAIL reset_oks got=%b want=0000",
        {bus.inst_addr_ok, bus.data_addr_ok,
         bus.inst_data_ok, bus.data_data_ok});
    end
    total++;
    if ({bus.arlen, bus.arburst, bus.awid, bus.wid,
         bus.wlast, bus.awburst} !== {8'd0, 2'b01, 4'd1,
         4'd1, 1'b1, 2'b01}) begin
      bad++;
      $display("FAIL reset_consts got=%h", {bus.arlen,
        bus.arburst, bus.awid, bus.wid, bus.wlast,
        bus.awburst});
    end
    cyc();
    rstn = 1;
  endtask

  task automatic test_fetch();
    cyc();
    bus.inst_req = 1; bus.inst_size = 2;
    bus.inst_addr = 32'h1c000000;
    #1;
    total++;
    if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b10) begin
      bad++;
      $display("FAIL fetch_grant got=%b want=10",
        {bus.inst_addr_ok, bus.data_addr_ok});
    end
    cyc();
    bus.inst_req = 0; bus.arready = 1;
    #1;
    total++;
    if ({bus.arvalid, bus.arid, bus.arsize, bus.araddr}
        !== {1'b1, 4'd0, 3'd2, 32'h1c000000}) begin
      bad++;
      $display("FAIL fetch_ar got=%b/%h/%h/%h want=1/0/2/1c000000",
        bus.arvalid, bus.arid, bus.arsize, bus.araddr);
    end
    cyc();
    bus.arready = 0;
    bus.rvalid = 1; bus.rdata = 32'h02800404;
    #1;
    total++;
    if ({bus.rready, bus.inst_data_ok, bus.data_data_ok,
         bus.inst_rdata} !== {3'b110, 32'h02800404}) begin
      bad++;
      $display("FAIL fetch_r got=%b%b%b/%h want=110/02800404",
        bus.rready, bus.inst_data_ok, bus.data_data_ok,
        bus.inst_rdata);
    end
    cyc();
    bus.rvalid = 0;
    #1;
    total++;
    if ({bus.inst_data_ok, bus.rready, bus.arvalid}
        !== 3'b000) begin
      bad++;
      $display("FAIL fetch_done got=%b want=000",
        {bus.inst_data_ok, bus.rready, bus.arvalid});
    end
  endtask

  task automatic test_tie();
    do_reset();
    bus.inst_req = 1; bus.inst_addr = 32'h40;
    bus.inst_size = 2;
    bus.data_req = 1; bus.data_wr = 0;
    bus.data_addr = 32'h80; bus.data_size = 2;
    #1;
    total++;
    if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b01) begin
      bad++;
      $display("FAIL tie_first got=%b want=01",
        {bus.inst_addr_ok, bus.data_addr_ok});
    end
    cyc();
    bus.arready = 1;
    #1;
    total++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.inst_addr_ok,
         bus.data_addr_ok} !== {1'b1, 4'd1, 32'h80, 2'b00}) begin
      bad++;
      $display("FAIL tie_ar1 got=%b/%h/%h/%b want=1/1/80/00",
        bus.arvalid, bus.arid, bus.araddr,
        {bus.inst_addr_ok, bus.data_addr_ok});
    end
    cyc();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h11;
    #1;
    total++;
    if ({bus.data_data_ok, bus.inst_data_ok, bus.data_rdata}
        !== {2'b10, 32'h11}) begin
      bad++;
      $display("FAIL tie_r1 got=%b/%h want=10/11",
        {bus.data_data_ok, bus.inst_data_ok}, bus.data_rdata);
    end
    cyc();
    bus.rvalid = 0;
    #1;
    total++;
    if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b10) begin
      bad++;
      $display("FAIL tie_second got=%b want=10",
        {bus.inst_addr_ok, bus.data_addr_ok});
    end
    cyc();
    bus.inst_req = 0; bus.data_req = 0; bus.arready = 1;
    #1;
    total++;
    if ({bus.arvalid, bus.arid, bus.araddr}
        !== {1'b1, 4'd0, 32'h40}) begin
      bad++;
      $display("FAIL tie_ar2 got=%b/%h/%h want=1/0/40",
        bus.arvalid, bus.arid, bus.araddr);
    end
    cyc();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h22;
    #1;
    total++;
    if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10) begin
      bad++;
      $display("FAIL tie_r2 got=%b want=10",
        {bus.inst_data_ok, bus.data_data_ok});
    end
    cyc();
    bus.rvalid = 0;
  endtask

  task automatic start_store();
    bus.data_req = 1; bus.data_wr = 1;
    bus.data_addr = 32'h8; bus.data_size = 2;
    bus.data_wdata = 32'hdeadbeef; bus.data_wstrb = 4'hf;
    #1;
    total++;
    if (bus.data_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL st_grant got=%b want=1", bus.data_addr_ok);
    end
    cyc();
    bus.data_req = 0; bus.data_wr = 0;
    bus.data_wdata = 0; bus.data_wstrb = 0;
  endtask

  task automatic test_store_same();
    start_store();
    bus.awready = 1; bus.wready = 1;
    #1;
    total++;
    if ({bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata,
         bus.wstrb, bus.awsize} !== {2'b11, 32'h8,
         32'hdeadbeef, 4'hf, 3'd2}) begin
      bad++;
      $display("FAIL st_aw_w got=%b%b/%h/%h/%h",
        bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata,
        bus.wstrb);
    end
    cyc();
    bus.awready = 0; bus.wready = 0; bus.bvalid = 1;
    #1;
    total++;
    if ({bus.awvalid, bus.wvalid, bus.bready,
         bus.data_data_ok} !== 4'b0011) begin
      bad++;
      $display("FAIL st_b got=%b want=0011",
        {bus.awvalid, bus.wvalid, bus.bready,
         bus.data_data_ok});
    end
    cyc();
    bus.bvalid = 0;
    #1;
    total++;
    if ({bus.bready, bus.data_data_ok} !== 2'b00) begin
      bad++;
      $display("FAIL st_done got=%b want=00",
        {bus.bready, bus.data_data_ok});
    end
  endtask

  task automatic test_store_split();
    cyc();
    start_store();
    bus.awready = 1;
    #1;
    total++;
    if ({bus.awvalid, bus.wvalid} !== 2'b11) begin
      bad++;
      $display("FAIL sp_c1 got=%b want=11",
        {bus.awvalid, bus.wvalid});
    end
    cyc();
    bus.awready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.wready = 1;
      #1;
      total++;
      if ({bus.awvalid, bus.wvalid, bus.wdata, bus.wstrb,
           bus.data_data_ok} !== {2'b01, 32'hdeadbeef,
           4'hf, 1'b0}) begin
        bad++;
        $display("FAIL sp_wait%0d got=%b%b/%h/%h/%b", i,
          bus.awvalid, bus.wvalid, bus.wdata, bus.wstrb,
          bus.data_data_ok);
      end
      cyc();
    end
    bus.wready = 0;
    #1;
    total++;
    if ({bus.wvalid, bus.bready, bus.data_data_ok}
        !== 3'b010) begin
      bad++;
      $display("FAIL sp_b_wait got=%b want=010",
        {bus.wvalid, bus.bready, bus.data_data_ok});
    end
    cyc();
    bus.bvalid = 1;
    #1;
    total++;
    if (bus.data_data_ok !== 1'b1) begin
      bad++;
      $display("FAIL sp_b got=%b want=1", bus.data_data_ok);
    end
    cyc();
    bus.bvalid = 0;
  endtask

  task automatic test_stall();
    bus.inst_req = 1; bus.inst_addr = 32'h100;
    bus.inst_size = 2;
    bus.data_req = 1; bus.data_addr = 32'h200;
    bus.data_wr = 0;
    #1;
    total++;
    if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b10) begin
      bad++;
      $display("FAIL stall_grant got=%b want=10",
        {bus.inst_addr_ok, bus.data_addr_ok});
    end
    cyc();
    bus.inst_req = 0; bus.inst_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({bus.arvalid, bus.araddr, bus.inst_addr_ok,
           bus.data_addr_ok} !== {1'b1, 32'h100, 2'b00}) begin
        bad++;
        $display("FAIL stall_c%0d got=%b/%h/%b want=1/100/00",
          i, bus.arvalid, bus.araddr,
          {bus.inst_addr_ok, bus.data_addr_ok});
      end
      cyc();
    end
    bus.arready = 1;
    cyc();
    bus.arready = 0; bus.data_req = 0;
    bus.rvalid = 1; bus.rdata = 32'h55;
    #1;
    total++;
    if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10) begin
      bad++;
      $display("FAIL stall_r got=%b want=10",
        {bus.inst_data_ok, bus.data_data_ok});
    end
    cyc();
    bus.rvalid = 0;
  endtask

  task automatic test_reset_mid();
    bus.data_req = 1; bus.data_wr = 0;
    bus.data_addr = 32'h300;
    cyc();
    bus.data_req = 0; bus.arready = 1;
    cyc();
    bus.arready = 0;
    #1;
    total++;
    if (bus.rready !== 1'b1) begin
      bad++;
      $display("FAIL rm_in_r got=%b want=1", bus.rready);
    end
    cyc();
    bus.rvalid = 1;
    rstn = 0;
    #1;
    total++;
    if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
         bus.bready, bus.inst_data_ok, bus.data_data_ok,
         bus.inst_addr_ok, bus.data_addr_ok} !== 9'b0) begin
      bad++;
      $display("FAIL rm_async got=%b want=0",
        {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
         bus.bready, bus.inst_data_ok, bus.data_data_ok,
         bus.inst_addr_ok, bus.data_addr_ok});
    end
    cyc();
    bus.rvalid = 0;
    rstn = 1;
    cyc();
    bus.inst_req = 1; bus.inst_addr = 32'h1c000010;
    #1;
    total++;
    if (bus.inst_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL rm_regrant got=%b want=1",
        bus.inst_addr_ok);
    end
    cyc();
    bus.inst_req = 0;
    #1;
    total++;
    if ({bus.arvalid, bus.arid, bus.araddr}
        !== {1'b1, 4'd0, 32'h1c000010}) begin
      bad++;
      $display("FAIL rm_ar got=%b/%h/%h want=1/0/1c000010",
        bus.arvalid, bus.arid, bus.araddr);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstn = 1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_tie();
    test_store_same();
    test_store_split();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
